// File: rtl/branch_flag_if.sv
// Handshake bundle for branch_flag_gen: decoded instruction and operands in,
// instruction plus Z/N/is_branch out. The master side drives inputs and consumes outputs.
interface branch_flag_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr_in;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           instr_out;
  logic                  Z;
  logic                  N;
  logic                  is_branch;
  logic [CNT_WIDTH-1:0]  branch_count;

  modport master (
    output in_valid, instr_in, rs_val, rt_val, flush, out_ready,
    input  in_ready, out_valid, instr_out, Z, N, is_branch, branch_count
  );

  modport slave (
    input  in_valid, instr_in, rs_val, rt_val, flush, out_ready,
    output in_ready, out_valid, instr_out, Z, N, is_branch, branch_count
  );
endinterface

// File: rtl/branch_flag_gen.sv
// Two-stage valid/ready pipeline producing Z/N branch flags aligned with the instruction.
// Optional BRANCH_FLAG_STATS_EN adds a wrapping count of emitted branch instructions.
module branch_flag_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  branch_flag_if.slave bus
);
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic                  s1_valid;
  logic [31:0]           s1_instr;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic                  s1_br;

  logic                  s2_valid;
  logic [31:0]           s2_instr;
  logic                  s2_z;
  logic                  s2_n;
  logic                  s2_br;

  logic                  s2_free;
  logic                  xfer;
  logic                  in_ready_int;
  logic                  accept;

  logic [5:0]            opcode;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  sel_br;

  assign opcode = bus.instr_in[31:26];

  // Single-operand branches compare rs against zero.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_br = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE: begin
        sel_a  = bus.rs_val;
        sel_b  = bus.rt_val;
        sel_br = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        sel_a  = bus.rs_val;
        sel_br = 1'b1;
      end
      default: ;
    endcase
  end

  assign s2_free      = !s2_valid || bus.out_ready;
  assign xfer         = s1_valid && s2_free;
  assign in_ready_int = !s1_valid || s2_free;
  assign accept       = bus.in_valid && in_ready_int;

  // Flush has priority over both an accept and a stage transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept)          s1_valid <= 1'b1;
      else if (xfer)       s1_valid <= 1'b0;
      if (xfer)            s2_valid <= 1'b1;
      else if (bus.out_ready) s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_instr <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_br    <= 1'b0;
      s2_instr <= '0;
      s2_z     <= 1'b0;
      s2_n     <= 1'b0;
      s2_br    <= 1'b0;
    end else begin
      if (accept) begin
        s1_instr <= bus.instr_in;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_br    <= sel_br;
      end
      if (xfer) begin
        s2_instr <= s1_instr;
        s2_z     <= s1_br && (s1_a == s1_b);
        s2_n     <= s1_br && ($signed(s1_a) < $signed(s1_b));
        s2_br    <= s1_br;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid;
  assign bus.instr_out = s2_instr;
  assign bus.Z         = s2_z;
  assign bus.N         = s2_n;
  assign bus.is_branch = s2_br;

`ifdef BRANCH_FLAG_STATS_EN
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (s2_valid && bus.out_ready && s2_br)
      cnt <= cnt + 1'b1;
  end

  assign bus.branch_count = cnt;
`else
  assign bus.branch_count = '0;
`endif
endmodule

// File: tb/tb_branch_flag_gen.sv
// Directed scoreboard bench for branch_flag_gen: expected {instr,Z,N,is_branch}
// is queued on each accepted input and compared on each output handshake.
module tb_branch_flag_gen;
  localparam int DW = 32;
  localparam int CW = 16;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;

  logic clk = 1'b0;
  logic reset;

  branch_flag_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  branch_flag_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          pops       = 0;
  int unsigned exp_cnt    = 0;
  logic [34:0] sb [$];

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [34:0] model(input logic [31:0] instr,
                                        input logic [DW-1:0] rs,
                                        input logic [DW-1:0] rt);
    logic [DW-1:0] a, b;
    logic br, z, n;
    a = '0; b = '0; br = 1'b0;
    case (instr[31:26])
      OP_BEQ, OP_BNE:              begin a = rs; b = rt; br = 1'b1; end
      OP_BLEZ, OP_BGTZ, OP_REGIMM: begin a = rs; br = 1'b1; end
      default: ;
    endcase
    z = br && (a == b);
    n = br && ($signed(a) < $signed(b));
    return {instr, z, n, br};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd3, 5'd7, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(output logic acc);
    logic pop;
    logic [34:0] e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    if (pop) begin
      pops++;
      if (bus.is_branch) exp_cnt++;
      if (sb.size() == 0) chk("spurious_output", {29'd0, bus.instr_out, bus.Z, bus.N, bus.is_branch}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("scoreboard_out", {29'd0, bus.instr_out, bus.Z, bus.N, bus.is_branch}, {29'd0, e});
      end
    end
    if (bus.flush) sb.delete();
    else if (acc) sb.push_back(model(bus.instr_in, bus.rs_val, bus.rt_val));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
    logic acc;
    bus.in_valid = 1'b1;
    bus.instr_in = instr;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) tick(acc);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && (sb.size() > 0 || bus.out_valid); k++) tick(acc);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    logic [34:0] snap;
    int p0;
    logic [5:0] ops [6];
    ops[0] = OP_BEQ; ops[1] = OP_BNE; ops[2] = OP_BLEZ;
    ops[3] = OP_BGTZ; ops[4] = OP_REGIMM; ops[5] = OP_ADDI;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.instr_in = '0; bus.rs_val = '0; bus.rt_val = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_outputs", {29'd0, bus.instr_out, bus.Z, bus.N, bus.is_branch}, 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_count", 64'(bus.branch_count), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // BEQ equal operands, 2-cycle latency
    send(mk(OP_BEQ, 16'h0010), 32'd5, 32'd5);
    chk("lat_cycle1_invalid", 64'(bus.out_valid), 64'd0);
    tick(acc);
    chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    chk("beq_flags", {61'd0, bus.Z, bus.N, bus.is_branch}, 64'b101);
    drain();

    // BGTZ negative, then BNE overflow-sensitive compare
    send(mk(OP_BGTZ, 16'h0020), 32'hFFFF_FFFF, 32'h0);
    send(mk(OP_BNE, 16'h0030), 32'h7FFF_FFFF, 32'h8000_0000);
    chk("bgtz_flags", {61'd0, bus.Z, bus.N, bus.is_branch}, 64'b011);
    tick(acc);
    chk("bne_ovf_flags", {61'd0, bus.Z, bus.N, bus.is_branch}, 64'b001);
    drain();

    // Backpressure: stall with both stages full
    p0 = pops;
    send(mk(OP_BEQ, 16'h0101), 32'd1, 32'd2);
    send(mk(OP_BLEZ, 16'h0102), 32'd0, 32'd9);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instr_in = mk(OP_REGIMM, 16'h0103);
    bus.rs_val = 32'h8000_0000; bus.rt_val = 32'd0;
    #1;
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    snap = {bus.instr_out, bus.Z, bus.N, bus.is_branch};
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      chk("stall_no_accept", 64'(acc), 64'd0);
      chk("stall_stable", {29'd0, bus.instr_out, bus.Z, bus.N, bus.is_branch}, {29'd0, snap});
    end
    bus.out_ready = 1'b1;
    send(mk(OP_REGIMM, 16'h0103), 32'h8000_0000, 32'd0);
    send(mk(OP_BNE, 16'h0104), 32'd4, 32'd4);
    drain();
    chk("stream_count", 64'(pops - p0), 64'd4);

    // Flush with both stages full and a new input presented
    bus.out_ready = 1'b0;
    send(mk(OP_BEQ, 16'h0201), 32'd7, 32'd7);
    send(mk(OP_BNE, 16'h0202), 32'd7, 32'd8);
    bus.in_valid = 1'b1; bus.instr_in = mk(OP_BEQ, 16'h0203);
    bus.rs_val = 32'd1; bus.rt_val = 32'd1;
    bus.flush = 1'b1;
    tick(acc);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_s1_empty", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(acc);
      chk("flush_no_output", 64'(bus.out_valid), 64'd0);
    end

    // Non-branch opcode: flags forced low
    send(mk(OP_ADDI, 16'h0301), 32'd3, 32'd3);
    tick(acc);
    chk("addi_flags", {bus.out_valid, 60'd0, bus.Z, bus.N, bus.is_branch}, {1'b1, 63'd0});
    drain();

    // More flag cases
    send(mk(OP_BLEZ, 16'h0401), 32'd0, 32'd5);
    send(mk(OP_BEQ, 16'h0402), 32'hFFFF_FFFF, 32'd1);
    send(mk(OP_REGIMM, 16'h0403), 32'd12, 32'd0);
    drain();

    // Full-throughput stream: in_ready must stay high
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1; bus.instr_in = mk(ops[k % 6], 16'(k));
      bus.rs_val = $urandom; bus.rt_val = (k % 3 == 0) ? bus.rs_val : $urandom;
      tick(acc);
      chk("throughput_accept", 64'(acc), 64'd1);
    end
    bus.in_valid = 1'b0;
    drain();

    // Randomized valid/ready mix
    for (int k = 0; k < 40; k++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.instr_in  = mk(ops[$urandom_range(0, 5)], 16'($urandom));
      bus.rs_val    = $urandom;
      bus.rt_val    = ($urandom_range(0, 2) == 0) ? bus.rs_val : $urandom;
      tick(acc);
    end
    bus.in_valid = 1'b0;
    drain();

`ifdef BRANCH_FLAG_STATS_EN
    chk("branch_count", 64'(bus.branch_count), 64'(exp_cnt % (1 << CW)));
`else
    chk("branch_count_tied", 64'(bus.branch_count), 64'd0);
`endif

    // Async reset mid-stream
    send(mk(OP_BEQ, 16'h0501), 32'd9, 32'd9);
    send(mk(OP_BNE, 16'h0502), 32'd1, 32'd2);
    bus.out_ready = 1'b0;
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(bus.out_valid), 64'd0);
    chk("async_reset_outputs", {29'd0, bus.instr_out, bus.Z, bus.N, bus.is_branch}, 64'd0);
    chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("async_reset_count", 64'(bus.branch_count), 64'd0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(mk(OP_BGTZ, 16'h0601), 32'd1, 32'd0);
    drain();
`ifdef BRANCH_FLAG_STATS_EN
    chk("count_after_reset", 64'(bus.branch_count), 64'(exp_cnt));
`else
    chk("count_after_reset", 64'(bus.branch_count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
